// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing constants and operation encoding for the
//               fifo_ctrl_4096 controller, its pointers and the bench.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEPTH  = 4096;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    // Accepted-operation code for one cycle: {write, read}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } op_t;

endpackage
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr
// Description : Wrapping address counter with enable and synchronous
//               active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int WIDTH = ADDR_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_ptr;

    // Power-of-two depth makes the natural binary rollover the wrap
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= r_ptr + c_one;
        end
    end

    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fifo_ctrl_4096.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_4096
// Description : Pointer, occupancy and flag controller driving the
//               fifo_4096 storage array.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl_4096 #(
    parameter int DEPTH    = fifo_pkg::DEPTH,
    parameter int AF_LEVEL = 4064,
    parameter int AE_LEVEL = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    output logic                     write,
    output logic                     read,
    output logic [$clog2(DEPTH)-1:0] wr_address,
    output logic [$clog2(DEPTH)-1:0] rd_address,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    import fifo_pkg::*;

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;

    localparam logic [c_cnt_w-1:0] c_full = DEPTH[c_cnt_w-1:0];
    localparam logic [c_cnt_w-1:0] c_af   = AF_LEVEL[c_cnt_w-1:0];
    localparam logic [c_cnt_w-1:0] c_ae   = AE_LEVEL[c_cnt_w-1:0];
    localparam logic [c_cnt_w-1:0] c_one  = {{(c_cnt_w-1){1'b0}}, 1'b1};

    logic               w_write;
    logic               w_read;
    op_t                w_op;
    logic [c_cnt_w-1:0] w_count_nxt;

    logic [c_cnt_w-1:0] r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_almost_full;
    logic               r_almost_empty;
    logic               r_rd_valid;
    logic               r_overflow;
    logic               r_underflow;

    // Strobes are gated by resetn so storage never sees a write during reset
    assign w_write = resetn & push & ~r_full;
    assign w_read  = resetn & pop & ~r_empty;
    assign w_op    = op_t'({w_write, w_read});

    always_comb begin
        w_count_nxt = r_count;
        case (w_op)
            OP_WR:   w_count_nxt = r_count + c_one;
            OP_RD:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_rd_valid     <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_full);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= c_af);
            r_almost_empty <= (w_count_nxt <= c_ae);
            r_rd_valid     <= w_read;
            if (push && r_full) begin
                r_overflow <= 1'b1;
            end
            if (pop && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    fifo_ptr #(.WIDTH(c_addr_w)) u_wr_ptr (
        .clk   (clk),
        .clr_n (resetn),
        .en    (w_write),
        .ptr   (wr_address)
    );

    fifo_ptr #(.WIDTH(c_addr_w)) u_rd_ptr (
        .clk   (clk),
        .clr_n (resetn),
        .en    (w_read),
        .ptr   (rd_address)
    );

    assign write        = w_write;
    assign read         = w_read;
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign rd_valid     = r_rd_valid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl_4096.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ctrl_4096
// Description : Directed scoreboard bench for fifo_ctrl_4096 with a
//               behavioural fifo_4096 storage array attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl_4096;

    import fifo_pkg::*;

    localparam int c_af = 4064;
    localparam int c_ae = 32;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] wr_address;
    logic [ADDR_W-1:0] rd_address;
    logic              rd_valid;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    logic [15:0] mem [0:DEPTH-1];
    logic [15:0] wdata = '0;
    logic [15:0] dout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_cnt = 0;
    int          m_wp = 0;
    int          m_rp = 0;
    logic        m_ov = 1'b0;
    logic        m_un = 1'b0;
    logic        m_rv = 1'b0;
    logic [15:0] seq = 16'h1000;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    fifo_ctrl_4096 dut (
        .clk          (clk),
        .resetn       (resetn),
        .push         (push),
        .pop          (pop),
        .write        (write),
        .read         (read),
        .wr_address   (wr_address),
        .rd_address   (rd_address),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Behavioural fifo_4096 storage, wired with no glue
    always @(posedge clk) begin
        if (write) mem[wr_address] <= wdata;
        if (read)  dout <= mem[rd_address];
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Monitor: every rd_valid word must be the oldest word pushed
    always @(negedge clk) begin
        if (rd_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_data at %0t: got %0d expected none (scoreboard empty)", $time, dout);
            end else begin
                chk("rd_data", int'(dout), int'(q.pop_front()));
            end
        end
    end

    task automatic step(input logic pu, input logic po, input logic rn);
        logic exp_w;
        logic exp_r;
        @(negedge clk);
        push   = pu;
        pop    = po;
        resetn = rn;
        wdata  = seq;
        #1;
        exp_w = rn && pu && (m_cnt != DEPTH);
        exp_r = rn && po && (m_cnt != 0);
        chk("write", int'(write), int'(exp_w));
        chk("read", int'(read), int'(exp_r));
        chk("wr_address", int'(wr_address), m_wp);
        chk("rd_address", int'(rd_address), m_rp);
        if (!rn) begin
            m_cnt = 0; m_wp = 0; m_rp = 0;
            m_ov = 1'b0; m_un = 1'b0; m_rv = 1'b0;
            q.delete();
        end else begin
            if (pu && !exp_w) m_ov = 1'b1;
            if (po && !exp_r) m_un = 1'b1;
            if (exp_w) begin
                q.push_back(seq);
                seq = seq + 16'd1;
                m_wp = (m_wp + 1) % DEPTH;
                m_cnt++;
            end
            if (exp_r) begin
                m_rp = (m_rp + 1) % DEPTH;
                m_cnt--;
            end
            m_rv = exp_r;
        end
        @(posedge clk);
        #1;
        chk("count", int'(count), m_cnt);
        chk("full", int'(full), int'(m_cnt == DEPTH));
        chk("empty", int'(empty), int'(m_cnt == 0));
        chk("almost_full", int'(almost_full), int'(m_cnt >= c_af));
        chk("almost_empty", int'(almost_empty), int'(m_cnt <= c_ae));
        chk("rd_valid", int'(rd_valid), int'(m_rv));
        chk("overflow", int'(overflow), int'(m_ov));
        chk("underflow", int'(underflow), int'(m_un));
    endtask

    initial begin
        // Reset, with push/pop held high to prove strobes stay low
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("reset_count", int'(count), 0);
        chk("reset_empty", int'(empty), 1);

        // Fill to full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 4096);

        // Push while full, then push+pop while full, then refill
        step(1'b1, 1'b0, 1'b1);
        chk("ovf_count", int'(count), 4096);
        step(1'b1, 1'b1, 1'b1);
        chk("full_both_count", int'(count), 4095);
        step(1'b1, 1'b0, 1'b1);

        // Drain to empty
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1);
        chk("drain_empty", int'(empty), 1);
        chk("ovf_sticky", int'(overflow), 1);

        // Push+pop while empty
        step(1'b1, 1'b1, 1'b1);
        chk("empty_both_count", int'(count), 1);
        chk("empty_both_unf", int'(underflow), 1);

        // Fill to 10, then concurrent traffic across pointer wrap
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5000; i++) step(1'b1, 1'b1, 1'b1);
        chk("steady_count", int'(count), 10);

        // Build to 100, reset mid-operation, first push lands at address 0
        for (int i = 0; i < 90; i++) step(1'b1, 1'b0, 1'b1);
        chk("pre_reset_count", int'(count), 100);
        step(1'b1, 1'b0, 1'b0);
        chk("post_reset_count", int'(count), 0);
        chk("post_reset_empty", int'(empty), 1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("scoreboard_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
